// File: rtl/modport_apb_slave.sv
// APB3 completer in front of a DEPTH x 32 register memory.
// Wait states are programmable, out-of-range accesses answer with PSLVERR,
// and every bus output comes straight from a flop.
module modport_apb_slave #(
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        PRESETn,   // active-high synchronous reset despite the name
  input  logic        PSEL1,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READY
  } state_t;

  state_t        state_reg;
  logic [AW-1:0] addr_reg;
  logic [31:0]   wdata_reg;
  logic          write_reg;
  logic          err_reg;
  logic [3:0]    cnt_reg;
  logic [31:0]   prdata_reg;
  logic          pready_reg;
  logic          pslverr_reg;

  logic [31:0]   mem_reg [DEPTH];
  logic [DEPTH-1:0] row_we;

  logic          setup;
  logic          setup_err;
  logic          commit;
  logic [31:0]   setup_rdata;
  logic [31:0]   wait_rdata;

  assign setup     = PSEL1 & ~PENABLE;
  // Full 32-bit compare so aliasing through the truncated index can never hit memory.
  assign setup_err = (PADDR >= 32'(DEPTH));
  // A write commits only on the completing edge of an error-free transfer.
  assign commit    = (state_reg == ST_READY) & PSEL1 & PENABLE & write_reg & ~err_reg;

  // Zero-wait reads are served from the live address at SETUP; delayed reads use the latch.
  assign setup_rdata = (setup_err | PWRITE)   ? 32'd0 : mem_reg[PADDR[AW-1:0]];
  assign wait_rdata  = (err_reg   | write_reg) ? 32'd0 : mem_reg[addr_reg];

  // Per-row write enables decoded from the latched address.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
    assign row_we[gi] = commit & (addr_reg == AW'(gi));
  end

  // Memory rows: cleared by reset, written on a committing completion edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (PRESETn) begin
        mem_reg[i] <= '0;
      end else if (row_we[i]) begin
        mem_reg[i] <= wdata_reg;
      end
    end
  end

  // Transfer FSM with registered PREADY/PSLVERR/PRDATA.
  always_ff @(posedge clk) begin
    if (PRESETn) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      write_reg   <= 1'b0;
      err_reg     <= 1'b0;
      cnt_reg     <= '0;
      prdata_reg  <= '0;
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (setup) begin
            addr_reg  <= PADDR[AW-1:0];
            wdata_reg <= PWDATA;
            write_reg <= PWRITE;
            err_reg   <= setup_err;
            if (WAIT_STATES == 0) begin
              state_reg   <= ST_READY;
              pready_reg  <= 1'b1;
              pslverr_reg <= setup_err;
              prdata_reg  <= setup_rdata;
            end else begin
              state_reg <= ST_WAIT;
              cnt_reg   <= 4'(WAIT_STATES);
            end
          end
        end
        ST_WAIT: begin
          if (!PSEL1) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
          end else if (PENABLE) begin
            cnt_reg <= cnt_reg - 4'd1;
            if (cnt_reg == 4'd1) begin
              state_reg   <= ST_READY;
              pready_reg  <= 1'b1;
              pslverr_reg <= err_reg;
              prdata_reg  <= wait_rdata;
            end
          end
        end
        ST_READY: begin
          // Completion and abort both return to IDLE; PRDATA is left holding.
          if (!PSEL1 || PENABLE) begin
            state_reg   <= ST_IDLE;
            pready_reg  <= 1'b0;
            pslverr_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          pready_reg  <= 1'b0;
          pslverr_reg <= 1'b0;
        end
      endcase
    end
  end

  assign PRDATA  = prdata_reg;
  assign PREADY  = pready_reg;
  assign PSLVERR = pslverr_reg;

endmodule

// File: tb/tb_modport_apb_slave.sv
// Directed bench for modport_apb_slave: one zero-wait and one two-wait instance,
// expected responses queued at SETUP and popped when PREADY appears.
module tb_modport_apb_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel0 = 1'b0;
  logic        psel_w = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;

  logic [31:0] prdata0, prdata_w;
  logic        pready0, pready_w;
  logic        pslverr0, pslverr_w;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] err;
    logic [31:0] acc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  modport_apb_slave #(.DEPTH(32), .WAIT_STATES(0)) dut0 (
    .clk(clk), .PRESETn(rst), .PSEL1(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
  );

  modport_apb_slave #(.DEPTH(32), .WAIT_STATES(2)) dut_w (
    .clk(clk), .PRESETn(rst), .PSEL1(psel_w), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_w), .PREADY(pready_w), .PSLVERR(pslverr_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] cur_ready(input bit w);
    return {31'd0, (w ? pready_w : pready0)};
  endfunction

  function automatic logic [31:0] cur_err(input bit w);
    return {31'd0, (w ? pslverr_w : pslverr0)};
  endfunction

  function automatic logic [31:0] cur_rdata(input bit w);
    return w ? prdata_w : prdata0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer; inputs are scrambled during ACCESS to prove latching.
  task automatic xfer(input bit w, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [31:0] exp_rdata, input bit exp_err, input string tag);
    exp_t it;
    int   acc;
    bit   done;
    it.rdata = exp_rdata;
    it.err   = {31'd0, exp_err};
    it.acc   = w ? 32'd3 : 32'd1;
    sb.push_back(it);
    if (w) psel_w = 1'b1; else psel0 = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    tick();
    penable = 1'b1;
    paddr   = ~addr;
    pwdata  = ~data;
    pwrite  = ~wr;
    acc  = 1;
    done = 1'b0;
    while (!done && acc <= 20) begin
      if (cur_ready(w) == 32'd1) begin
        it = sb.pop_front();
        check({tag, " access_cycle"}, 32'(acc), it.acc);
        check({tag, " pslverr"}, cur_err(w), it.err);
        check({tag, " prdata"}, cur_rdata(w), it.rdata);
        tick();
        check({tag, " pready_low_after"}, cur_ready(w), 32'd0);
        done = 1'b1;
      end else begin
        tick();
        acc++;
      end
    end
    if (!done) begin
      check({tag, " pready_timeout"}, {31'd0, done}, 32'd1);
      void'(sb.pop_front());
    end
    $display("xfer %s dut=%0d wr=%0d addr=%0h data=%0h acc=%0d", tag, w, wr, addr, data, acc);
    psel0   = 1'b0;
    psel_w  = 1'b0;
    penable = 1'b0;
  endtask

  initial begin
    // Reset for two cycles then release.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst pready0",   cur_ready(1'b0), 32'd0);
    check("rst pslverr0",  cur_err(1'b0),   32'd0);
    check("rst prdata0",   cur_rdata(1'b0), 32'd0);
    check("rst pready_w",  cur_ready(1'b1), 32'd0);
    check("rst pslverr_w", cur_err(1'b1),   32'd0);
    check("rst prdata_w",  cur_rdata(1'b1), 32'd0);
    $display("reset released");

    // PENABLE without SETUP must be ignored.
    psel0 = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'd9; pwdata = 32'h77;
    tick();
    check("no_setup pready0", cur_ready(1'b0), 32'd0);
    psel0 = 1'b0; penable = 1'b0;
    tick();
    $display("enable-without-setup ignored");

    xfer(1'b0, 1'b0, 32'd5, 32'd0, 32'd0, 1'b0, "rd5_after_reset");

    // Zero-wait write then read, issued back-to-back.
    xfer(1'b0, 1'b1, 32'd3, 32'hDEADBEEF, 32'd0, 1'b0, "wr3");
    xfer(1'b0, 1'b0, 32'd3, 32'd0, 32'hDEADBEEF, 1'b0, "rd3");
    xfer(1'b0, 1'b0, 32'd9, 32'd0, 32'd0, 1'b0, "rd9_untouched");

    // Two-wait instance.
    xfer(1'b1, 1'b1, 32'd3, 32'hDEADBEEF, 32'd0, 1'b0, "w_wr3");
    xfer(1'b1, 1'b0, 32'd3, 32'd0, 32'hDEADBEEF, 1'b0, "w_rd3");
    xfer(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1, "w_rd_err");

    // Error write must not alias onto address 0.
    xfer(1'b0, 1'b1, 32'd0, 32'h1111_0000, 32'd0, 1'b0, "wr0");
    xfer(1'b0, 1'b1, 32'd32, 32'h1234_5678, 32'd0, 1'b1, "wr32_err");
    xfer(1'b0, 1'b0, 32'd0, 32'd0, 32'h1111_0000, 1'b0, "rd0_unchanged");
    xfer(1'b0, 1'b0, 32'd32, 32'd0, 32'd0, 1'b1, "rd32_err");

    // Back-to-back write/read of address 1.
    xfer(1'b0, 1'b1, 32'd1, 32'hA, 32'd0, 1'b0, "b2b_wr1");
    xfer(1'b0, 1'b0, 32'd1, 32'd0, 32'hA, 1'b0, "b2b_rd1");

    // Abort in WAIT: write of 0xFF to addr 7 never commits.
    psel_w = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'd7; pwdata = 32'hFF;
    tick();
    penable = 1'b1;
    tick();
    check("abort pready_in_wait", cur_ready(1'b1), 32'd0);
    psel_w = 1'b0; penable = 1'b0;
    tick();
    check("abort pready_after", cur_ready(1'b1), 32'd0);
    $display("abort issued on dut_w addr 7");
    xfer(1'b1, 1'b0, 32'd7, 32'd0, 32'd0, 1'b0, "w_rd7_after_abort");

    // Reset while READY on a read of addr 1.
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'd1; pwdata = 32'd0;
    tick();
    check("rst_ready pready_before", cur_ready(1'b0), 32'd1);
    check("rst_ready prdata_before", cur_rdata(1'b0), 32'hA);
    penable = 1'b1;
    rst = 1'b1;
    tick();
    check("rst_ready pready",  cur_ready(1'b0), 32'd0);
    check("rst_ready pslverr", cur_err(1'b0),   32'd0);
    check("rst_ready prdata",  cur_rdata(1'b0), 32'd0);
    rst = 1'b0; psel0 = 1'b0; penable = 1'b0;
    tick();
    $display("reset asserted in READY");
    xfer(1'b0, 1'b0, 32'd3, 32'd0, 32'd0, 1'b0, "rd3_after_reset");
    xfer(1'b1, 1'b0, 32'd3, 32'd0, 32'd0, 1'b0, "w_rd3_after_reset");

    check("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
